// File: rtl/shift_tx_sequencer.sv
// shift_tx_sequencer
//
// Drives a shift_reg_start_done instance as a serial transmitter. A parallel word is captured
// on a start pulse in IDLE. The block issues one LOAD command and then N-1 SHIFT_L commands,
// each with a Trigger pulse. Every bit stays on the shifter's q for exactly DIV clocks.
// A completed word raises done_tick for one cycle. A cancelled word raises abort_tick and
// reloads the shifter with zero.
//
// Ports
//   clk_i         system clock, rising edge
//   reset_i       asynchronous active-high reset, shared with the shifter
//   start_i       transmit request, sampled only in IDLE
//   din_i         word to send, captured when start is accepted
//   lsb_first_i   captured with din_i; 1 sends din_i[0] first
//   abort_i       synchronous cancel, acted on in LOAD and SHIFT
//   last_tick_i   shifter reports that its final bit is on q
//   sh_ctrl_o     shifter command: 00 NOP, 01 SHIFT_L, 11 LOAD
//   sh_d_o        shifter parallel load data
//   sh_trigger_o  shifter command strobe
//   bit_valid_o   shifter q carries a payload bit
//   busy_o        word in flight (LOAD, SHIFT, DONE, ABORT)
//   done_tick_o   one-cycle pulse when a word completes
//   abort_tick_o  one-cycle pulse when a word is cancelled

module shift_tx_sequencer #(
  parameter int unsigned N   = 8,
  parameter int unsigned DIV = 16
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [N-1:0] din_i,
  input  logic         lsb_first_i,
  input  logic         abort_i,
  input  logic         last_tick_i,
  output logic [1:0]   sh_ctrl_o,
  output logic [N-1:0] sh_d_o,
  output logic         sh_trigger_o,
  output logic         bit_valid_o,
  output logic         busy_o,
  output logic         done_tick_o,
  output logic         abort_tick_o
);

  localparam int unsigned       TimerW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TimerW-1:0] TimerMax = TimerW'(DIV - 1);

  localparam logic [1:0] CtrlNop    = 2'b00;
  localparam logic [1:0] CtrlShiftL = 2'b01;
  localparam logic [1:0] CtrlLoad   = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShift,
    StDone,
    StAbort
  } state_e;

  state_e              state_q, state_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [N-1:0]        word_q,  word_d;
  logic                timer_at_max;

  // The shifter always presents its MSB on q. To send LSB first, the word is mirrored.
  function automatic logic [N-1:0] bit_reverse(input logic [N-1:0] w);
    logic [N-1:0] r;
    for (int i = 0; i < int'(N); i++) begin
      r[i] = w[N-1-i];
    end
    return r;
  endfunction

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      timer_q <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      word_q  <= word_d;
    end
  end

  // With DIV = 1 the timer never leaves 0, so every SHIFT cycle is a terminal cycle.
  assign timer_at_max = (timer_q == TimerMax);

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    word_d       = word_q;
    sh_ctrl_o    = CtrlNop;
    sh_d_o       = '0;
    sh_trigger_o = 1'b0;
    bit_valid_o  = 1'b0;
    busy_o       = 1'b0;
    done_tick_o  = 1'b0;
    abort_tick_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          word_d  = lsb_first_i ? bit_reverse(din_i) : din_i;
          state_d = StLoad;
        end
      end

      StLoad: begin
        busy_o       = 1'b1;
        sh_ctrl_o    = CtrlLoad;
        sh_d_o       = word_q;
        sh_trigger_o = 1'b1;
        timer_d      = '0;
        state_d      = abort_i ? StAbort : StShift;
      end

      StShift: begin
        busy_o      = 1'b1;
        bit_valid_o = 1'b1;
        if (abort_i) begin
          // Cancel wins over any shift or completion due this cycle.
          state_d = StAbort;
        end else if (timer_at_max) begin
          timer_d = '0;
          if (last_tick_i) begin
            state_d = StDone;
          end else begin
            sh_ctrl_o    = CtrlShiftL;
            sh_trigger_o = 1'b1;
          end
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end

      StDone: begin
        busy_o      = 1'b1;
        done_tick_o = 1'b1;
        state_d     = StIdle;
      end

      StAbort: begin
        // Loading zero clears both the shifter data and its bit counter.
        busy_o       = 1'b1;
        sh_ctrl_o    = CtrlLoad;
        sh_trigger_o = 1'b1;
        abort_tick_o = 1'b1;
        state_d      = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_tx_sequencer.sv
`timescale 1ns/1ps

module tb_shift_tx_sequencer;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       lsb = 1'b0;
  logic [7:0] din = 8'h00;
  logic       sel = 1'b0;   // 0: DIV=4 instance, 1: DIV=1 instance

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // DIV = 4 instance
  logic       start_a, abort_a, last_a, trig_a, bv_a, busy_a, done_a, abt_a;
  logic [1:0] ctrl_a;
  logic [7:0] d_a;
  // DIV = 1 instance
  logic       start_b, abort_b, last_b, trig_b, bv_b, busy_b, done_b, abt_b;
  logic [1:0] ctrl_b;
  logic [7:0] d_b;

  assign start_a = start & ~sel;
  assign abort_a = abort & ~sel;
  assign start_b = start & sel;
  assign abort_b = abort & sel;

  shift_tx_sequencer #(.N(N), .DIV(4)) u_dut_a (
    .clk_i(clk), .reset_i(rst), .start_i(start_a), .din_i(din), .lsb_first_i(lsb),
    .abort_i(abort_a), .last_tick_i(last_a), .sh_ctrl_o(ctrl_a), .sh_d_o(d_a),
    .sh_trigger_o(trig_a), .bit_valid_o(bv_a), .busy_o(busy_a), .done_tick_o(done_a),
    .abort_tick_o(abt_a)
  );

  shift_tx_sequencer #(.N(N), .DIV(1)) u_dut_b (
    .clk_i(clk), .reset_i(rst), .start_i(start_b), .din_i(din), .lsb_first_i(lsb),
    .abort_i(abort_b), .last_tick_i(last_b), .sh_ctrl_o(ctrl_b), .sh_d_o(d_b),
    .sh_trigger_o(trig_b), .bit_valid_o(bv_b), .busy_o(busy_b), .done_tick_o(done_b),
    .abort_tick_o(abt_b)
  );

  // Stand-in shifters: MSB on q, counter of shifts since the last LOAD.
  logic [7:0] sreg_a, sreg_b;
  logic [2:0] scnt_a, scnt_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_a <= '0;
      scnt_a <= '0;
    end else if (trig_a) begin
      case (ctrl_a)
        2'b11: begin sreg_a <= d_a; scnt_a <= '0; end
        2'b01: begin sreg_a <= {sreg_a[6:0], 1'b0}; scnt_a <= scnt_a + 3'd1; end
        2'b10: begin sreg_a <= {1'b0, sreg_a[7:1]}; scnt_a <= scnt_a + 3'd1; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_b <= '0;
      scnt_b <= '0;
    end else if (trig_b) begin
      case (ctrl_b)
        2'b11: begin sreg_b <= d_b; scnt_b <= '0; end
        2'b01: begin sreg_b <= {sreg_b[6:0], 1'b0}; scnt_b <= scnt_b + 3'd1; end
        2'b10: begin sreg_b <= {1'b0, sreg_b[7:1]}; scnt_b <= scnt_b + 3'd1; end
        default: ;
      endcase
    end
  end

  assign last_a = (scnt_a == 3'd7);
  assign last_b = (scnt_b == 3'd7);

  // Observation of the selected instance
  logic       o_q, o_last, o_trig, o_bv, o_busy, o_done, o_abt;
  logic [1:0] o_ctrl;
  logic [7:0] o_d;
  assign o_q    = sel ? sreg_b[7] : sreg_a[7];
  assign o_last = sel ? last_b : last_a;
  assign o_trig = sel ? trig_b : trig_a;
  assign o_bv   = sel ? bv_b   : bv_a;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_done = sel ? done_b : done_a;
  assign o_abt  = sel ? abt_b  : abt_a;
  assign o_ctrl = sel ? ctrl_b : ctrl_a;
  assign o_d    = sel ? d_b    : d_a;

  // Reference: payload bit k as it must appear on the line.
  function automatic logic exp_bit(input logic [7:0] w, input logic lf, input int k);
    return lf ? w[k] : w[N-1-k];
  endfunction

  // Sends one word from IDLE and compares every cycle against the timing rules.
  task automatic run_word(input logic s, input logic [7:0] w, input logic lf,
                          output int done_at, output int trig_cnt,
                          output int bv_cnt, output int lt_cnt);
    int div;
    int last_cyc;
    logic exp_bv, exp_busy, exp_done, exp_q;
    logic [4:0] exp_v, obs_v;
    div      = s ? 1 : 4;
    last_cyc = 2 + N * div;
    done_at  = -1;
    trig_cnt = 0;
    bv_cnt   = 0;
    lt_cnt   = 0;
    sel      = s;
    din      = w;
    lsb      = lf;
    start    = 1'b1;
    for (int t = 0; t <= last_cyc + 1; t++) begin
      @(negedge clk);
      exp_bv   = (t >= 2) && (t <= 1 + N * div);
      exp_busy = (t >= 1) && (t <= last_cyc);
      exp_done = (t == last_cyc);
      exp_q    = exp_bv ? exp_bit(w, lf, (t - 2) / div) : 1'b0;
      exp_v    = {exp_busy, exp_bv, exp_done, 1'b0, exp_q};
      obs_v    = {o_busy, o_bv, o_done, o_abt, exp_bv ? o_q : 1'b0};
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL word_cycle din=%h lsb=%0b t=%0d {busy,bv,done,abt,q} got=%b exp=%b",
                 w, lf, t, obs_v, exp_v);
      end
      if (o_trig) trig_cnt++;
      if (o_bv) bv_cnt++;
      if (o_bv && o_last) lt_cnt++;
      if (o_done && done_at < 0) done_at = t;
      @(posedge clk);
      #1;
      start = 1'b0;
      din   = 8'($urandom);
      lsb   = 1'($urandom);
    end
  endtask

  task automatic test_reset();
    logic [15:0] obs;
    obs = {ctrl_a, d_a, trig_a, bv_a, busy_a, done_a, abt_a, sreg_a[7]};
    checks++;
    if (obs !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs_a got=%h exp=0000", obs);
    end
    obs = {ctrl_b, d_b, trig_b, bv_b, busy_b, done_b, abt_b, sreg_b[7]};
    checks++;
    if (obs !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs_b got=%h exp=0000", obs);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    obs = {ctrl_a, d_a, trig_a, bv_a, busy_a, done_a, abt_a, 1'b0};
    checks++;
    if (obs !== 16'h0) begin
      errors++;
      $display("FAIL idle_outputs_a got=%h exp=0000", obs);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_msb_a5();
    int done_at, trig_cnt, bv_cnt, lt_cnt;
    run_word(1'b0, 8'hA5, 1'b0, done_at, trig_cnt, bv_cnt, lt_cnt);
    checks++;
    if (done_at !== 34) begin
      errors++;
      $display("FAIL a5_done_cycle got=%0d exp=34", done_at);
    end
    checks++;
    if (trig_cnt !== 8) begin
      errors++;
      $display("FAIL a5_trigger_count got=%0d exp=8", trig_cnt);
    end
  endtask

  task automatic test_lsb_01();
    int done_at, trig_cnt, bv_cnt, lt_cnt;
    run_word(1'b0, 8'h01, 1'b1, done_at, trig_cnt, bv_cnt, lt_cnt);
    checks++;
    if (done_at !== 34) begin
      errors++;
      $display("FAIL lsb01_done_cycle got=%0d exp=34", done_at);
    end
  endtask

  task automatic test_div1();
    int done_at, trig_cnt, bv_cnt, lt_cnt;
    run_word(1'b1, 8'hFF, 1'b0, done_at, trig_cnt, bv_cnt, lt_cnt);
    checks++;
    if (done_at !== 10) begin
      errors++;
      $display("FAIL div1_done_cycle got=%0d exp=10", done_at);
    end
    checks++;
    if (bv_cnt !== 8) begin
      errors++;
      $display("FAIL div1_bit_valid_cycles got=%0d exp=8", bv_cnt);
    end
    checks++;
    if (lt_cnt !== 1) begin
      errors++;
      $display("FAIL div1_last_tick_seen got=%0d exp=1", lt_cnt);
    end
    checks++;
    if (trig_cnt !== 8) begin
      errors++;
      $display("FAIL div1_trigger_count got=%0d exp=8", trig_cnt);
    end
  endtask

  task automatic test_random();
    int done_at, trig_cnt, bv_cnt, lt_cnt;
    logic s, lf;
    logic [7:0] w;
    for (int i = 0; i < 8; i++) begin
      s  = 1'($urandom);
      lf = 1'($urandom);
      w  = 8'($urandom);
      run_word(s, w, lf, done_at, trig_cnt, bv_cnt, lt_cnt);
      checks++;
      if (done_at !== (2 + N * (s ? 1 : 4)) || trig_cnt !== N) begin
        errors++;
        $display("FAIL random_word din=%h div=%0d done_at=%0d trig=%0d exp_done=%0d exp_trig=%0d",
                 w, s ? 1 : 4, done_at, trig_cnt, 2 + N * (s ? 1 : 4), N);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w0;
    logic       lf0;
    logic [1:0] obs, expv;
    int load_at;
    int waited;
    sel     = 1'b0;
    w0      = 8'($urandom);
    lf0     = 1'($urandom);
    load_at = -1;
    for (int t = 0; t < 40; t++) begin
      start = 1'b1;
      din   = (t == 0) ? w0 : 8'($urandom);
      lsb   = (t == 0) ? lf0 : 1'($urandom);
      @(negedge clk);
      if (t >= 2 && t <= 33) begin
        obs  = {o_bv, o_q};
        expv = {1'b1, exp_bit(w0, lf0, (t - 2) / 4)};
        checks++;
        if (obs !== expv) begin
          errors++;
          $display("FAIL b2b_first_word t=%0d {bv,q} got=%b exp=%b", t, obs, expv);
        end
      end
      if (t > 1 && o_ctrl == 2'b11 && o_trig && load_at < 0) load_at = t;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    checks++;
    if (load_at !== 36) begin
      errors++;
      $display("FAIL b2b_second_load got=%0d exp=36", load_at);
    end
    waited = 0;
    while (busy_a && waited < 100) begin
      @(posedge clk);
      #1;
      waited++;
    end
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain busy got=%b exp=0", busy_a);
    end
  endtask

  task automatic test_abort();
    logic [2:0]  obs3, exp3;
    logic [12:0] obs_ld;
    logic [1:0]  obs_sh;
    sel = 1'b0;
    din = 8'($urandom);
    lsb = 1'($urandom);
    for (int t = 0; t < 16; t++) begin
      start = (t == 0);
      abort = (t == 10);
      @(negedge clk);
      obs3 = {busy_a, done_a, abt_a};
      exp3 = {(t >= 1 && t <= 11), 1'b0, (t == 11)};
      checks++;
      if (obs3 !== exp3) begin
        errors++;
        $display("FAIL abort_cycle t=%0d {busy,done,abt} got=%b exp=%b", t, obs3, exp3);
      end
      if (t == 11) begin
        obs_ld = {ctrl_a, d_a, trig_a, abt_a, busy_a};
        checks++;
        if (obs_ld !== {2'b11, 8'h00, 1'b1, 1'b1, 1'b1}) begin
          errors++;
          $display("FAIL abort_load {ctrl,d,trig,abt,busy} got=%b exp=%b",
                   obs_ld, {2'b11, 8'h00, 3'b111});
        end
      end
      if (t >= 12) begin
        obs_sh = {sreg_a[7], last_a};
        checks++;
        if (obs_sh !== 2'b00) begin
          errors++;
          $display("FAIL abort_shifter_clear t=%0d {q,last} got=%b exp=00", t, obs_sh);
        end
      end
      @(posedge clk);
      #1;
    end
    abort = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [14:0] obs;
    logic [1:0]  ticks;
    int done_at, trig_cnt, bv_cnt, lt_cnt;
    logic [7:0] w;
    sel = 1'b0;
    din = 8'($urandom);
    lsb = 1'($urandom);
    for (int t = 0; t < 15; t++) begin
      start = (t == 0);
      @(posedge clk);
      #1;
    end
    checks++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre busy got=%b exp=1", busy_a);
    end
    rst = 1'b1;
    #1;
    obs = {ctrl_a, d_a, trig_a, bv_a, busy_a, done_a, abt_a};
    checks++;
    if (obs !== 15'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs got=%h exp=0000", obs);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      ticks = {done_a, abt_a};
      checks++;
      if (ticks !== 2'b00 || busy_a !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_after t=%0d {done,abt} got=%b busy=%b exp=00/0",
                 t, ticks, busy_a);
      end
      @(posedge clk);
      #1;
    end
    w = 8'($urandom);
    run_word(1'b0, w, 1'($urandom), done_at, trig_cnt, bv_cnt, lt_cnt);
    checks++;
    if (done_at !== 34 || trig_cnt !== 8) begin
      errors++;
      $display("FAIL reset_mid_resend done_at=%0d trig=%0d exp=34/8", done_at, trig_cnt);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_msb_a5();
    test_lsb_01();
    test_div1();
    test_random();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_tx_sequencer.md
# shift_tx_sequencer

Sequencer that drives one `shift_reg_start_done` instance as a serial transmitter. It accepts a parallel word on a start pulse and issues the LOAD and SHIFT_L commands with Trigger pulses. It holds each bit on the shifter's `q` for exactly DIV clock cycles and reports completion with a one-cycle done tick. It sits between a parallel producer (CPU or register bank) and the shifter, and owns all of the shifter's `ctrl`, `d` and `Trigger` inputs.

## Interface
- N, 8: word width; must equal the shifter's N; N >= 2.
- DIV, 16: clock cycles per serial bit; DIV >= 1. The bit timer is clog2(DIV) bits wide, minimum 1.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; wired to the same net as the shifter's reset.
- start  in  1  request; sampled only in IDLE.
- din  in  N  word to send; captured on the cycle start is accepted.
- lsb_first  in  1  captured with din. 1: din[0] is sent first. 0: din[N-1] is sent first.
- abort  in  1  synchronous cancel; acted on only in LOAD or SHIFT.
- last_tick  in  1  from the shifter's `last_tick`.
- sh_ctrl  out  2  to the shifter's `ctrl`. Encoding: 00 NOP, 01 SHIFT_L, 10 SHIFT_R (never issued), 11 LOAD.
- sh_d  out  N  to the shifter's `d`.
- sh_trigger  out  1  to the shifter's `Trigger`.
- bit_valid  out  1  high while the shifter's `q` carries a payload bit.
- busy  out  1  high in LOAD, SHIFT, DONE and ABORT.
- done_tick  out  1  one-cycle pulse when a word completes.
- abort_tick  out  1  one-cycle pulse when a word is cancelled.

## Operation
- States: IDLE, LOAD, SHIFT, DONE, ABORT. State is held in registers. Outputs are decoded from state plus the bit timer.
- Reset values: state IDLE, timer 0, word register 0. All outputs are 0, so sh_ctrl = NOP.
- The shifter outputs its MSB on `q`. To send LSB first, the block bit-reverses din into the word register. A SHIFT_R command is never issued.
- IDLE:
  - Outputs: NOP, sh_trigger = 0, busy = 0.
  - On start = 1: capture din (reversed if lsb_first = 1) and go to LOAD.
- LOAD (exactly 1 cycle):
  - Outputs: sh_ctrl = LOAD, sh_d = word register, sh_trigger = 1.
  - Clear the timer, then go to SHIFT.
- SHIFT:
  - bit_valid = 1. The timer counts 0 to DIV-1 and wraps to 0.
  - When the timer is at DIV-1 and last_tick = 0: sh_ctrl = SHIFT_L, sh_trigger = 1 for that cycle.
  - When the timer is at DIV-1 and last_tick = 1: sh_trigger = 0, go to DONE.
  - In all other SHIFT cycles: NOP, sh_trigger = 0.
- DONE (1 cycle): done_tick = 1, NOP, then go to IDLE.
- ABORT (1 cycle):
  - Outputs: sh_ctrl = LOAD, sh_d = 0, sh_trigger = 1, abort_tick = 1.
  - Clears the shifter register and its counter. Then go to IDLE.
- Priority:
  - abort beats any timer or last_tick action in LOAD and SHIFT.
  - abort and start are ignored in DONE and ABORT.
  - start is ignored whenever busy = 1. There is no queueing.
- din and lsb_first may change freely after acceptance; the word register holds the captured value.

## Timing
- Let cycle 0 be the cycle where start = 1 is sampled in IDLE.
- Cycle 1: LOAD. The shifter loads at the end of this cycle.
- Cycles 2 to 1+DIV: bit 0 on `q`. Bit k occupies cycles 2+k·DIV to 1+(k+1)·DIV.
- Cycle 2+N·DIV: DONE, with done_tick = 1.
- Cycle 3+N·DIV: IDLE; a new start is accepted here at the earliest.
- Cycles from start to done_tick: 2 + N·DIV.
- Number of sh_trigger pulses per completed word: exactly N (1 LOAD + N-1 SHIFT_L).
- DIV = 1: the timer is always at its terminal value, so a shift is issued every SHIFT cycle until last_tick.
- Abort sampled in cycle c: ABORT occurs in cycle c+1, IDLE in c+2. done_tick is never asserted for that word.
- Reset mid-word: IDLE on the next cycle view, with no done_tick or abort_tick. The shifter is cleared by the shared reset.

## Test plan
- N=8, DIV=4, lsb_first=0, din=8'hA5, start for 1 cycle:
  - `q` sequence is 1,0,1,0,0,1,0,1, each held 4 cycles.
  - done_tick occurs at cycle 34.
  - 8 sh_trigger pulses are counted.
- Same setup with lsb_first=1, din=8'h01:
  - `q` = 1 for cycles 2–5, then 0 for the remaining 28 bit cycles.
- DIV=1, din=8'hFF:
  - bit_valid is high for 8 consecutive cycles.
  - done_tick occurs at cycle 10.
  - The shifter's last_tick is seen exactly once.
- start held high for 40 cycles with din changing every cycle:
  - Only the cycle-0 din is sent.
  - The second word starts its LOAD at cycle 36 (start accepted in IDLE at 35).
- abort at cycle 10 of a DIV=4 word:
  - Cycle 11: ABORT, with LOAD of 0 and abort_tick = 1.
  - The shifter's q = 0 and last_tick = 0 afterwards.
  - No done_tick; busy = 0 from cycle 12.
- reset asserted at cycle 15 of a word:
  - All outputs are 0 immediately.
  - After release, a new start sends correctly with normal timing.
